// File: rtl/oka_9bit_seq_ctrl.sv
// Sequential 9x9 carry-less multiplier: one shared 5x5 sub-multiplier over three cycles.
// Optional macro OKA_SEQ_OPCOUNT_EN adds the op_count output.
module oka_9bit_seq_ctrl #(
  parameter int N = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] y,
`ifdef OKA_SEQ_OPCOUNT_EN
  output logic [15:0]    op_count,
`endif
  output logic           busy
);

  // state | meaning
  // IDLE  | waiting for an operand pair (in_ready high)
  // MUL_E | even-part product pe = ae*be
  // MUL_O | odd-part product po = ao*bo
  // MUL_M | middle product, recombination into y
  // DONE  | y presented until out_ready
  typedef enum logic [2:0] {IDLE, MUL_E, MUL_O, MUL_M, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [8:0]     pe_q, pe_d, po_q, po_d;
  logic [2*N-2:0] y_q, y_d;
  logic [4:0]     ae, ao, be, bo, sub_x, sub_z;
  logic [8:0]     sub_p;

  function automatic logic [4:0] clmul3(input logic [2:0] x, input logic [2:0] z);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 3; i++)
      if (z[i]) r = r ^ ({2'b00, x} << i);
    return r;
  endfunction

  // Interleave zeros between coefficients: p(x) -> p(x^2).
  function automatic logic [8:0] spread5(input logic [4:0] p);
    logic [8:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r[2*i] = p[i];
    return r;
  endfunction

  function automatic logic [16:0] spread9(input logic [8:0] p);
    logic [16:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[2*i] = p[i];
    return r;
  endfunction

  // The 5x5 sub-multiplier is itself an overlap-free Karatsuba split over 3x3 products.
  function automatic logic [8:0] clmul5(input logic [4:0] x, input logic [4:0] z);
    logic [2:0] xe, xo, ze, zo;
    logic [4:0] qe, qo, qm;
    xe = {x[4], x[2], x[0]};
    xo = {1'b0, x[3], x[1]};
    ze = {z[4], z[2], z[0]};
    zo = {1'b0, z[3], z[1]};
    qe = clmul3(xe, ze);
    qo = clmul3(xo, zo);
    qm = clmul3(xe ^ xo, ze ^ zo);
    return spread5(qe) ^ (spread5(qo) << 2) ^ (spread5(qm ^ qe ^ qo) << 1);
  endfunction

  assign ae    = {a_q[8], a_q[6], a_q[4], a_q[2], a_q[0]};
  assign ao    = {1'b0,   a_q[7], a_q[5], a_q[3], a_q[1]};
  assign be    = {b_q[8], b_q[6], b_q[4], b_q[2], b_q[0]};
  assign bo    = {1'b0,   b_q[7], b_q[5], b_q[3], b_q[1]};
  assign sub_p = clmul5(sub_x, sub_z);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = MUL_E;
      MUL_E:   state_d = MUL_O;
      MUL_O:   state_d = MUL_M;
      MUL_M:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    sub_x     = ae ^ ao;
    sub_z     = be ^ bo;
    case (state_q)
      MUL_E: begin sub_x = ae; sub_z = be; end
      MUL_O: begin sub_x = ao; sub_z = bo; end
      default: ;
    endcase
  end

  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    pe_d = pe_q;
    po_d = po_q;
    y_d  = y_q;
    case (state_q)
      IDLE:  if (in_valid) begin a_d = a; b_d = b; end
      MUL_E: pe_d = sub_p;
      MUL_O: po_d = sub_p;
      MUL_M: y_d  = spread9(pe_q) ^ (spread9(po_q) << 2) ^ (spread9(sub_p ^ pe_q ^ po_q) << 1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      pe_q <= '0;
      po_q <= '0;
      y_q  <= '0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      pe_q <= pe_d;
      po_q <= po_d;
      y_q  <= y_d;
    end
  end

  assign y = y_q;

`ifdef OKA_SEQ_OPCOUNT_EN
  logic [15:0] op_cnt_q, op_cnt_d;

  always_comb begin
    op_cnt_d = op_cnt_q;
    if (out_valid && out_ready) op_cnt_d = op_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_cnt_q <= '0;
    else     op_cnt_q <= op_cnt_d;
  end

  assign op_count = op_cnt_q;
`endif

endmodule

// File: doc/oka_9bit_seq_ctrl.md
OKA_9BIT_SEQ_CTRL -- requirements
Module: oka_9bit_seq_ctrl

Interface
REQ-001 SHALL have parameter: N, 9, operand width in bits; 9 is the only supported value.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  operand pair offered.
REQ-005 SHALL have port: in_ready  output  1  controller can accept an operand pair.
REQ-006 SHALL have port: a  input  N  multiplicand, GF(2) polynomial, bit i = coefficient of x^i.
REQ-007 SHALL have port: b  input  N  multiplier, same encoding as a.
REQ-008 SHALL have port: out_valid  output  1  product y valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts y.
REQ-010 SHALL have port: y  output  2N-1  carry-less product a*b over GF(2).
REQ-011 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL time-multiplex exactly one 5-bit overlap-free Karatsuba sub-multiplier (5x5 -> 9-bit carry-less) across the three sub-products.
REQ-013 SHALL split operands by parity: ae = {a8,a6,a4,a2,a0}, ao = {0,a7,a5,a3,a1}; be and bo likewise.
REQ-014 SHALL use FSM states IDLE -> MUL_E -> MUL_O -> MUL_M -> DONE -> IDLE, one cycle per state except IDLE and DONE.
REQ-015 SHALL assert in_ready only in IDLE; on in_valid && in_ready, register a and b and move to MUL_E.
REQ-016 SHALL ignore changes on a, b and in_valid outside the accept cycle.
REQ-017 SHALL, in MUL_E, register pe = ae*be (9 bits).
REQ-018 SHALL, in MUL_O, register po = ao*bo (9 bits).
REQ-019 SHALL, in MUL_M, compute pm = (ae^ao)*(be^bo) and register y = S(pe) ^ (S(po)<<2) ^ (S(pm^pe^po)<<1).
REQ-020 S(p) SHALL place bit i of p at bit 2i, with zeros in the odd bits; y SHALL equal the full 17-bit carry-less product of a and b.
REQ-021 SHALL assert out_valid only in DONE, first in the 4th cycle after the accept edge.
REQ-022 SHALL hold y and out_valid stable in DONE until out_ready is high, then return to IDLE.
REQ-023 SHALL not let in_ready combinationally follow out_ready: minimum spacing between accepts is 5 cycles.
REQ-024 SHALL leave y holding its last product after the DONE->IDLE transition until the next MUL_M.
REQ-025 An out_ready pulse outside DONE SHALL have no effect.

Reset
REQ-026 On rst high SHALL immediately force: state=IDLE, in_ready=1 after release (0 while rst high), out_valid=0, busy=0, y=0, pe=po=0, operand registers=0.
REQ-027 rst mid-operation (any state) SHALL abort; the aborted product SHALL never appear with out_valid=1.
REQ-028 On the first clk edge after rst deasserts, in_valid high SHALL be accepted.

Configuration
REQ-029 Macro OKA_SEQ_OPCOUNT_EN defined: SHALL add output op_count [15:0] counting completed output handshakes, reset 0, wrapping 65535 -> 0.
REQ-030 OKA_SEQ_OPCOUNT_EN undefined: SHALL omit the op_count port and counter; all other behaviour identical.

Verification
REQ-031 a=9'h003, b=9'h005, out_ready=1 -> out_valid in the 4th cycle after accept, y=17'h0000F, in_ready high in the next cycle.
REQ-032 a=9'h1FF, b=9'h1FF -> y=17'h15555; a=9'h100, b=9'h100 -> y=17'h10000.
REQ-033 out_ready held 0 for 10 cycles in DONE with a=9'h003, b=9'h003 -> y=17'h00005 stable, in_ready=0 throughout; release -> IDLE.
REQ-034 rst pulsed during MUL_O -> out_valid stays 0; next op a=9'h002, b=9'h002 -> y=17'h00004.
REQ-035 in_valid held high continuously, 100 random pairs -> every y matches a reference carry-less product; accepts exactly 5 cycles apart; with OKA_SEQ_OPCOUNT_EN, op_count=100.
